tnoc_xy_route_selector: RTL and testbench

- Output stage directly downstream of the per-port virtual-channel selector.
- Takes the single arbitrated flit stream and decodes each head flit's destination with dimension-ordered XY routing.
- Latches the chosen output port for the whole packet and presents flits through a one-entry output register.
- Steers each flit to exactly one of five router output ports: local, X+, X-, Y+, Y-.

---
 rtl/tnoc_xy_route_selector.sv | 147 ++++++++++++++
 tb/tb_tnoc_xy_route_selector.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tnoc_xy_route_selector.sv
// XY route selector: decodes head flit destination, steers packet to one of five output ports.
// Latency: 1 cycle from input acceptance to registered output.
// Backpressure: o_ready low while the output register is full and the selected port is not ready.
module tnoc_xy_route_selector #(
    parameter int X_WIDTH    = 3,
    parameter int Y_WIDTH    = 3,
    parameter int VC_WIDTH   = 1,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [X_WIDTH-1:0]    i_id_x,
    input  logic [Y_WIDTH-1:0]    i_id_y,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_head,
    input  logic                  i_tail,
    input  logic [VC_WIDTH-1:0]   i_vc,
    input  logic [X_WIDTH-1:0]    i_dest_x,
    input  logic [Y_WIDTH-1:0]    i_dest_y,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [4:0]            o_valid,
    input  logic [4:0]            i_ready,
    output logic                  o_head,
    output logic                  o_tail,
    output logic [VC_WIDTH-1:0]   o_vc,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_error
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    localparam logic [4:0] PORT_LOCAL = 5'b00001;
    localparam logic [4:0] PORT_XP    = 5'b00010;
    localparam logic [4:0] PORT_XM    = 5'b00100;
    localparam logic [4:0] PORT_YP    = 5'b01000;
    localparam logic [4:0] PORT_YM    = 5'b10000;

    logic [0:0]            state_q, state_d;
    logic [4:0]            route_q, route_d;
    logic                  full_q, full_d;
    logic [4:0]            port_q, port_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [VC_WIDTH-1:0]   vc_q, vc_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  error_q, error_d;

    logic [4:0] route_dec;
    logic       drain;
    logic       accept;
    logic       load;
    logic [4:0] load_port;

    // Dimension-ordered decode: resolve X completely before looking at Y.
    always_comb begin
        route_dec = PORT_LOCAL;
        if (i_dest_x > i_id_x)      route_dec = PORT_XP;
        else if (i_dest_x < i_id_x) route_dec = PORT_XM;
        else if (i_dest_y > i_id_y) route_dec = PORT_YP;
        else if (i_dest_y < i_id_y) route_dec = PORT_YM;
    end

    assign o_valid = port_q & {5{full_q}};
    assign drain   = |(o_valid & i_ready);
    assign o_ready = !full_q || drain;
    assign accept  = i_valid && o_ready;

    // Packet FSM: heads pick a route, body/tail flits reuse it, protocol violations raise an error.
    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        error_d   = 1'b0;
        load      = 1'b0;
        load_port = route_q;
        if (accept) begin
            if (i_head) begin
                // A head while a packet is open abandons the old packet and starts a new one.
                if (state_q == S_ACTIVE) error_d = 1'b1;
                route_d   = route_dec;
                load      = 1'b1;
                load_port = route_dec;
                state_d   = i_tail ? S_IDLE : S_ACTIVE;
            end else if (state_q == S_IDLE) begin
                // Orphan body/tail flit: consume and drop it.
                error_d = 1'b1;
            end else begin
                load      = 1'b1;
                load_port = route_q;
                if (i_tail) state_d = S_IDLE;
            end
        end
    end

    // Output register next-state: load wins over drain so a new flit can follow a draining one directly.
    always_comb begin
        full_d = full_q;
        port_d = port_q;
        head_d = head_q;
        tail_d = tail_q;
        vc_d   = vc_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            port_d = load_port;
            head_d = i_head;
            tail_d = i_tail;
            vc_d   = i_vc;
            data_d = i_data;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    // State and output register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            route_q <= 5'b00000;
            full_q  <= 1'b0;
            port_q  <= 5'b00000;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            vc_q    <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            full_q  <= full_d;
            port_q  <= port_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            vc_q    <= vc_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

    assign o_head  = head_q;
    assign o_tail  = tail_q;
    assign o_vc    = vc_q;
    assign o_data  = data_q;
    assign o_error = error_q;

endmodule

// File: tb/tb_tnoc_xy_route_selector.sv
// Directed bench for tnoc_xy_route_selector with router id (2,2).
// Inputs change on the falling edge; outputs are checked on the falling edge after the capturing rising edge.
// Each scenario task does its own comparisons against hand-computed values.
module tb_tnoc_xy_route_selector;

    logic        clk;
    logic        rst;
    logic [2:0]  i_id_x, i_id_y;
    logic        i_valid;
    logic        o_ready;
    logic        i_head, i_tail;
    logic [0:0]  i_vc;
    logic [2:0]  i_dest_x, i_dest_y;
    logic [63:0] i_data;
    logic [4:0]  o_valid;
    logic [4:0]  i_ready;
    logic        o_head, o_tail;
    logic [0:0]  o_vc;
    logic [63:0] o_data;
    logic        o_error;

    int pass_cnt = 0;
    int total    = 0;

    tnoc_xy_route_selector #(
        .X_WIDTH(3), .Y_WIDTH(3), .VC_WIDTH(1), .DATA_WIDTH(64)
    ) dut (
        .clk(clk), .rst(rst), .i_id_x(i_id_x), .i_id_y(i_id_y),
        .i_valid(i_valid), .o_ready(o_ready), .i_head(i_head), .i_tail(i_tail),
        .i_vc(i_vc), .i_dest_x(i_dest_x), .i_dest_y(i_dest_y), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_head(o_head), .o_tail(o_tail),
        .o_vc(o_vc), .o_data(o_data), .o_error(o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic h, input logic t, input logic [0:0] vc,
                         input logic [2:0] dx, input logic [2:0] dy, input logic [63:0] d);
        i_valid  = v;
        i_head   = h;
        i_tail   = t;
        i_vc     = vc;
        i_dest_x = dx;
        i_dest_y = dy;
        i_data   = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 3'd0, 64'hFFFF);
        i_ready = 5'b11111;
        cyc();
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 64'h0);
        #1;
        total++; if (o_valid !== 5'b00000) $display("FAIL reset_valid got=%b exp=00000", o_valid); else pass_cnt++;
        total++; if (o_data !== 64'h0) $display("FAIL reset_data got=%h exp=0", o_data); else pass_cnt++;
        total++; if ({o_head, o_tail, o_vc, o_error} !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", {o_head, o_tail, o_vc, o_error}); else pass_cnt++;
        total++; if (o_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", o_ready); else pass_cnt++;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single_flit();
        i_ready = 5'b00010;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 3'd0, 64'hA5A5_0000_1234_5678);
        #1;
        total++; if (o_ready !== 1'b1) $display("FAIL single_ready_in got=%b exp=1", o_ready); else pass_cnt++;
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 64'h0);
        #1;
        total++; if (o_valid !== 5'b00010) $display("FAIL single_valid got=%b exp=00010", o_valid); else pass_cnt++;
        total++; if (o_data !== 64'hA5A5_0000_1234_5678) $display("FAIL single_data got=%h exp=a5a5000012345678", o_data); else pass_cnt++;
        total++; if ({o_head, o_tail, o_vc} !== 3'b111) $display("FAIL single_flags got=%b exp=111", {o_head, o_tail, o_vc}); else pass_cnt++;
        total++; if (o_ready !== 1'b1) $display("FAIL single_ready_out got=%b exp=1", o_ready); else pass_cnt++;
        cyc();
        total++; if (o_valid !== 5'b00000) $display("FAIL single_empty got=%b exp=00000", o_valid); else pass_cnt++;
    endtask

    task automatic test_multi_flit();
        i_ready = 5'b10000;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, (k == 0), (k == 3), 1'b0, 3'd2, 3'd0, 64'd100 + 64'(k));
            cyc();
            #1;
            total++; if (o_valid !== 5'b10000) $display("FAIL multi_valid%0d got=%b exp=10000", k, o_valid); else pass_cnt++;
            total++; if (o_data !== 64'd100 + 64'(k)) $display("FAIL multi_data%0d got=%0d exp=%0d", k, o_data, 100 + k); else pass_cnt++;
            total++; if ({o_head, o_tail} !== {(k == 0), (k == 3)}) $display("FAIL multi_flags%0d got=%b exp=%b", k, {o_head, o_tail}, {(k == 0), (k == 3)}); else pass_cnt++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 64'h0);
        cyc();
        total++; if (o_valid !== 5'b00000) $display("FAIL multi_empty got=%b exp=00000", o_valid); else pass_cnt++;
        // A body flit now must be rejected, which shows the FSM is back in IDLE.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 64'd999);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 64'h0);
        #1;
        total++; if (o_error !== 1'b1) $display("FAIL multi_idle_err got=%b exp=1", o_error); else pass_cnt++;
        cyc();
    endtask

    task automatic test_back_to_back();
        i_ready = 5'b11111;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 3'd2, 64'd1);
        cyc();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd2, 64'd2);
        #1;
        total++; if (o_valid !== 5'b00001) $display("FAIL b2b_local got=%b exp=00001", o_valid); else pass_cnt++;
        total++; if (o_data !== 64'd1) $display("FAIL b2b_data1 got=%0d exp=1", o_data); else pass_cnt++;
        total++; if (o_ready !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", o_ready); else pass_cnt++;
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 64'h0);
        #1;
        total++; if (o_valid !== 5'b00100) $display("FAIL b2b_xm got=%b exp=00100", o_valid); else pass_cnt++;
        total++; if (o_data !== 64'd2) $display("FAIL b2b_data2 got=%0d exp=2", o_data); else pass_cnt++;
        cyc();
        total++; if (o_valid !== 5'b00000) $display("FAIL b2b_empty got=%b exp=00000", o_valid); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        i_ready = 5'b11101;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 3'd2, 64'd10);
        cyc();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 64'd11);
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (o_ready !== 1'b0) $display("FAIL bp_ready%0d got=%b exp=0", k, o_ready); else pass_cnt++;
            total++; if (o_valid !== 5'b00010) $display("FAIL bp_valid%0d got=%b exp=00010", k, o_valid); else pass_cnt++;
            total++; if ({o_data, o_head, o_tail} !== {64'd10, 1'b1, 1'b0}) $display("FAIL bp_hold%0d got=%0d/%b%b exp=10/10", k, o_data, o_head, o_tail); else pass_cnt++;
            cyc();
        end
        i_ready = 5'b11111;
        #1;
        total++; if (o_ready !== 1'b1) $display("FAIL bp_resume_ready got=%b exp=1", o_ready); else pass_cnt++;
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 64'h0);
        #1;
        total++; if (o_valid !== 5'b00010) $display("FAIL bp_tail_valid got=%b exp=00010", o_valid); else pass_cnt++;
        total++; if ({o_data, o_tail} !== {64'd11, 1'b1}) $display("FAIL bp_tail_data got=%0d/%b exp=11/1", o_data, o_tail); else pass_cnt++;
        cyc();
        total++; if (o_valid !== 5'b00000) $display("FAIL bp_empty got=%b exp=00000", o_valid); else pass_cnt++;
    endtask

    task automatic test_idle_error();
        i_ready = 5'b11111;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 3'd5, 64'd55);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 64'h0);
        #1;
        total++; if (o_error !== 1'b1) $display("FAIL idle_err_pulse got=%b exp=1", o_error); else pass_cnt++;
        total++; if (o_valid !== 5'b00000) $display("FAIL idle_err_valid got=%b exp=00000", o_valid); else pass_cnt++;
        cyc();
        total++; if (o_error !== 1'b0) $display("FAIL idle_err_clear got=%b exp=0", o_error); else pass_cnt++;
    endtask

    task automatic test_active_head_error();
        i_ready = 5'b11111;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 3'd2, 64'd20);
        cyc();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 3'd2, 64'd21);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 64'h0);
        #1;
        total++; if (o_valid !== 5'b00001) $display("FAIL act_head_valid got=%b exp=00001", o_valid); else pass_cnt++;
        total++; if (o_error !== 1'b1) $display("FAIL act_head_err got=%b exp=1", o_error); else pass_cnt++;
        cyc();
        total++; if (o_error !== 1'b0) $display("FAIL act_head_err_clear got=%b exp=0", o_error); else pass_cnt++;
    endtask

    task automatic test_reset_mid_packet();
        i_ready = 5'b11111;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 3'd3, 64'hDEAD);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 64'h0);
        #1;
        total++; if (o_valid !== 5'b01000) $display("FAIL mid_yp got=%b exp=01000", o_valid); else pass_cnt++;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        total++; if (o_valid !== 5'b00000) $display("FAIL mid_rst_valid got=%b exp=00000", o_valid); else pass_cnt++;
        total++; if ({o_data, o_head, o_tail, o_vc, o_error} !== 68'h0) $display("FAIL mid_rst_outs got=%h/%b%b%b%b exp=0", o_data, o_head, o_tail, o_vc, o_error); else pass_cnt++;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 64'hBEEF);
        cyc();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 3'd2, 64'd77);
        #1;
        total++; if (o_error !== 1'b1) $display("FAIL mid_drop_err got=%b exp=1", o_error); else pass_cnt++;
        total++; if (o_valid !== 5'b00000) $display("FAIL mid_drop_valid got=%b exp=00000", o_valid); else pass_cnt++;
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 64'h0);
        #1;
        total++; if (o_valid !== 5'b00100) $display("FAIL mid_fresh_valid got=%b exp=00100", o_valid); else pass_cnt++;
        total++; if (o_data !== 64'd77) $display("FAIL mid_fresh_data got=%0d exp=77", o_data); else pass_cnt++;
        total++; if (o_error !== 1'b0) $display("FAIL mid_fresh_err got=%b exp=0", o_error); else pass_cnt++;
        cyc();
    endtask

    initial begin
        i_id_x = 3'd2;
        i_id_y = 3'd2;
        rst    = 1'b1;
        i_ready = 5'b00000;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 64'h0);
        test_reset();
        test_single_flit();
        test_multi_flit();
        test_back_to_back();
        test_backpressure();
        test_idle_error();
        test_active_head_error();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
